// File: rtl/uart_rx_checker.sv
// UART receiver with a fixed-byte pattern checker and saturating
// match / mismatch / framing-error counters for link bring-up.
module uart_rx_checker #(
  parameter int unsigned CLOCKS_PER_BAUD = 104,
  parameter logic [7:0]  EXPECTED        = 8'h45,
  parameter int unsigned COUNT_WIDTH     = 8
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic                   rx_i,
  output logic [7:0]             data_o,
  output logic                   valid_o,
  output logic                   frame_error_o,
  output logic                   last_ok_o,
  output logic [COUNT_WIDTH-1:0] match_count_o,
  output logic [COUNT_WIDTH-1:0] mismatch_count_o,
  output logic [COUNT_WIDTH-1:0] error_count_o
);

  localparam int unsigned TW = $clog2(CLOCKS_PER_BAUD) + 1;

  localparam logic [TW-1:0] HALF = TW'(CLOCKS_PER_BAUD / 2);
  localparam logic [TW-1:0] FULL = TW'(CLOCKS_PER_BAUD);
  localparam logic [TW-1:0] T1   = TW'(1);

  localparam logic [COUNT_WIDTH-1:0] CMAX = '1;
  localparam logic [COUNT_WIDTH-1:0] C1   = COUNT_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_e;

  state_e                 state_q;
  logic                   sync1_q;
  logic                   rx_s_q;
  logic                   rx_q;
  logic [TW-1:0]          timer_q;
  logic [2:0]             bit_q;
  logic [7:0]             shift_q;
  logic [7:0]             data_q;
  logic                   valid_q;
  logic                   ferr_q;
  logic                   ok_q;
  logic [COUNT_WIDTH-1:0] match_q;
  logic [COUNT_WIDTH-1:0] mis_q;
  logic [COUNT_WIDTH-1:0] err_q;

  logic                   tick_d;
  logic                   hit_d;
  logic [TW-1:0]          timer_dec_d;

  // Timer reaches 1 exactly on a sample cycle.
  assign tick_d      = (timer_q == T1);
  assign timer_dec_d = timer_q - T1;
  assign hit_d       = (shift_q == EXPECTED);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      sync1_q <= 1'b0;
      rx_s_q  <= 1'b0;
      rx_q    <= 1'b0;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ok_q    <= 1'b0;
      match_q <= '0;
      mis_q   <= '0;
      err_q   <= '0;
    end else begin
      sync1_q <= rx_i;
      rx_s_q  <= sync1_q;
      rx_q    <= rx_s_q;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (rx_q && !rx_s_q) begin
            timer_q <= HALF;
            state_q <= START;
          end
        end
        START: begin
          if (!tick_d) begin
            timer_q <= timer_dec_d;
          end else if (rx_s_q) begin
            state_q <= IDLE;
          end else begin
            timer_q <= FULL;
            bit_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (!tick_d) begin
            timer_q <= timer_dec_d;
          end else begin
            shift_q[bit_q] <= rx_s_q;
            timer_q        <= FULL;
            if (bit_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (!tick_d) begin
            timer_q <= timer_dec_d;
          end else if (rx_s_q) begin
            data_q  <= shift_q;
            valid_q <= 1'b1;
            ok_q    <= hit_d;
            if (hit_d) begin
              if (match_q != CMAX) match_q <= match_q + C1;
            end else begin
              if (mis_q != CMAX) mis_q <= mis_q + C1;
            end
            state_q <= IDLE;
          end else begin
            ferr_q <= 1'b1;
            if (err_q != CMAX) err_q <= err_q + C1;
            state_q <= BRK;
          end
        end
        BRK: begin
          if (rx_s_q) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_o           = data_q;
  assign valid_o          = valid_q;
  assign frame_error_o    = ferr_q;
  assign last_ok_o        = ok_q;
  assign match_count_o    = match_q;
  assign mismatch_count_o = mis_q;
  assign error_count_o    = err_q;

endmodule

// File: tb/tb_uart_rx_checker.sv
// Bench for uart_rx_checker: directed scenarios plus random frames
// against a frame-level model with saturating counts.
module tb_uart_rx_checker;

  localparam int CPB = 104;
  localparam int CW = 2;
  localparam logic [7:0] EXP = 8'h45;
  localparam int MAXC = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx = 1'b1;
  logic [7:0] data_o;
  logic valid_o, frame_error_o, last_ok_o;
  logic [CW-1:0] match_o, mis_o, err_o;

  always #5 clk = ~clk;

  uart_rx_checker #(
    .CLOCKS_PER_BAUD(CPB),
    .EXPECTED(EXP),
    .COUNT_WIDTH(CW)
  ) dut (
    .clock_i(clk),
    .reset_i(rst),
    .rx_i(rx),
    .data_o(data_o),
    .valid_o(valid_o),
    .frame_error_o(frame_error_o),
    .last_ok_o(last_ok_o),
    .match_count_o(match_o),
    .mismatch_count_o(mis_o),
    .error_count_o(err_o)
  );

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_both = 0;

  always @(negedge clk) begin
    if (valid_o) n_valid++;
    if (frame_error_o) n_ferr++;
    if (valid_o && frame_error_o) n_both++;
  end

  int m_match, m_mis, m_err;
  logic [7:0] m_data;
  logic m_ok;

  function automatic void model_reset();
    m_match = 0; m_mis = 0; m_err = 0;
    m_data = 8'h00; m_ok = 1'b0;
  endfunction

  function automatic void model_frame(logic [7:0] b, logic stop_ok);
    if (stop_ok) begin
      m_data = b;
      m_ok = (b == EXP);
      if (b == EXP) begin
        if (m_match < MAXC) m_match++;
      end else begin
        if (m_mis < MAXC) m_mis++;
      end
    end else begin
      if (m_err < MAXC) m_err++;
    end
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop;
    idle(CPB);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx = 1'b1;
    idle(5);
    rst = 1'b0;
    model_reset();
    idle(5);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({data_o, valid_o, frame_error_o, last_ok_o} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outs: got %h/%b/%b/%b required 0",
               data_o, valid_o, frame_error_o, last_ok_o);
    end
    checks++;
    if ({match_o, mis_o, err_o} !== '0) begin
      errors++;
      $display("FAIL reset_counts: got %0d/%0d/%0d required 0/0/0",
               match_o, mis_o, err_o);
    end
  endtask

  task automatic test_match();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h45, 1'b1);
    model_frame(8'h45, 1'b1);
    idle(10);
    checks++;
    if (n_valid - v0 !== 1 || n_ferr - f0 !== 0) begin
      errors++;
      $display("FAIL match_pulses: valid=%0d ferr=%0d required 1/0",
               n_valid - v0, n_ferr - f0);
    end
    checks++;
    if (data_o !== m_data || last_ok_o !== m_ok) begin
      errors++;
      $display("FAIL match_data: got %h/%b required %h/%b",
               data_o, last_ok_o, m_data, m_ok);
    end
    checks++;
    if (match_o !== CW'(m_match) || mis_o !== CW'(m_mis)
        || err_o !== CW'(m_err)) begin
      errors++;
      $display("FAIL match_counts: got %0d/%0d/%0d required %0d/%0d/%0d",
               match_o, mis_o, err_o, m_match, m_mis, m_err);
    end
  endtask

  task automatic test_mismatch();
    int v0;
    v0 = n_valid;
    send_frame(8'h49, 1'b1);
    model_frame(8'h49, 1'b1);
    idle(10);
    checks++;
    if (n_valid - v0 !== 1) begin
      errors++;
      $display("FAIL mis_pulses: valid=%0d required 1", n_valid - v0);
    end
    checks++;
    if (data_o !== m_data || last_ok_o !== m_ok) begin
      errors++;
      $display("FAIL mis_data: got %h/%b required %h/%b",
               data_o, last_ok_o, m_data, m_ok);
    end
    checks++;
    if (match_o !== CW'(m_match) || mis_o !== CW'(m_mis)) begin
      errors++;
      $display("FAIL mis_counts: got %0d/%0d required %0d/%0d",
               match_o, mis_o, m_match, m_mis);
    end
  endtask

  task automatic test_framing();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h45, 1'b0);
    model_frame(8'h45, 1'b0);
    idle(3 * CPB);
    checks++;
    if (n_valid - v0 !== 0 || n_ferr - f0 !== 1) begin
      errors++;
      $display("FAIL ferr_low: valid=%0d ferr=%0d required 0/1",
               n_valid - v0, n_ferr - f0);
    end
    rx = 1'b1;
    idle(2 * CPB);
    checks++;
    if (n_valid - v0 !== 0 || n_ferr - f0 !== 1) begin
      errors++;
      $display("FAIL ferr_release: valid=%0d ferr=%0d required 0/1",
               n_valid - v0, n_ferr - f0);
    end
    checks++;
    if (err_o !== CW'(m_err) || data_o !== m_data || last_ok_o !== m_ok) begin
      errors++;
      $display("FAIL ferr_state: got err=%0d %h/%b required %0d %h/%b",
               err_o, data_o, last_ok_o, m_err, m_data, m_ok);
    end
  endtask

  task automatic test_glitch();
    int v0, f0;
    v0 = n_valid; f0 = n_ferr;
    rx = 1'b0;
    idle(20);
    rx = 1'b1;
    idle(2 * CPB);
    checks++;
    if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin
      errors++;
      $display("FAIL glitch_pulses: valid=%0d ferr=%0d required 0/0",
               n_valid - v0, n_ferr - f0);
    end
    checks++;
    if (match_o !== CW'(m_match) || mis_o !== CW'(m_mis)
        || err_o !== CW'(m_err)) begin
      errors++;
      $display("FAIL glitch_counts: got %0d/%0d/%0d required %0d/%0d/%0d",
               match_o, mis_o, err_o, m_match, m_mis, m_err);
    end
  endtask

  task automatic test_back_to_back();
    int v0;
    v0 = n_valid;
    for (int i = 0; i < 5; i++) begin
      send_frame(8'h45, 1'b1);
      model_frame(8'h45, 1'b1);
    end
    idle(10);
    checks++;
    if (n_valid - v0 !== 5) begin
      errors++;
      $display("FAIL b2b_pulses: valid=%0d required 5", n_valid - v0);
    end
    checks++;
    if (match_o !== CW'(m_match) || match_o !== CW'(MAXC)) begin
      errors++;
      $display("FAIL b2b_saturate: match=%0d required %0d", match_o, m_match);
    end
    checks++;
    if (data_o !== 8'h45 || last_ok_o !== 1'b1) begin
      errors++;
      $display("FAIL b2b_data: got %h/%b required 45/1", data_o, last_ok_o);
    end
  endtask

  task automatic test_reset_mid_frame();
    int v0, f0;
    logic [7:0] b;
    b = 8'h45;
    rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = b[4];
    idle(CPB / 2);
    v0 = n_valid; f0 = n_ferr;
    rst = 1'b1;
    idle(3);
    rx = 1'b1;
    idle(3);
    rst = 1'b0;
    model_reset();
    idle(1);
    checks++;
    if ({data_o, last_ok_o, match_o, mis_o, err_o} !== '0) begin
      errors++;
      $display("FAIL rstmid_outs: got %h/%b/%0d/%0d/%0d required all 0",
               data_o, last_ok_o, match_o, mis_o, err_o);
    end
    idle(2 * CPB);
    checks++;
    if (n_valid - v0 !== 0 || n_ferr - f0 !== 0) begin
      errors++;
      $display("FAIL rstmid_pulses: valid=%0d ferr=%0d required 0/0",
               n_valid - v0, n_ferr - f0);
    end
    send_frame(8'h45, 1'b1);
    model_frame(8'h45, 1'b1);
    idle(10);
    checks++;
    if (match_o !== CW'(m_match) || data_o !== m_data
        || last_ok_o !== m_ok) begin
      errors++;
      $display("FAIL rstmid_after: got %0d/%h/%b required %0d/%h/%b",
               match_o, data_o, last_ok_o, m_match, m_data, m_ok);
    end
  endtask

  task automatic test_random();
    int v0, f0, ev, ef;
    logic [7:0] b;
    logic ok;
    do_reset();
    for (int n = 0; n < 12; n++) begin
      b = ($urandom_range(0, 3) == 0) ? EXP : 8'($urandom);
      ok = ($urandom_range(0, 4) != 0);
      v0 = n_valid; f0 = n_ferr;
      send_frame(b, ok);
      model_frame(b, ok);
      if (!ok) begin
        idle(CPB * $urandom_range(1, 3));
        rx = 1'b1;
      end
      idle(10 + $urandom_range(0, 40));
      ev = ok ? 1 : 0;
      ef = ok ? 0 : 1;
      checks++;
      if (n_valid - v0 !== ev || n_ferr - f0 !== ef) begin
        errors++;
        $display("FAIL rand_pulses[%0d]: byte %h valid=%0d ferr=%0d required %0d/%0d",
                 n, b, n_valid - v0, n_ferr - f0, ev, ef);
      end
      checks++;
      if (data_o !== m_data || last_ok_o !== m_ok) begin
        errors++;
        $display("FAIL rand_data[%0d]: got %h/%b required %h/%b",
                 n, data_o, last_ok_o, m_data, m_ok);
      end
      checks++;
      if (match_o !== CW'(m_match) || mis_o !== CW'(m_mis)
          || err_o !== CW'(m_err)) begin
        errors++;
        $display("FAIL rand_counts[%0d]: got %0d/%0d/%0d required %0d/%0d/%0d",
                 n, match_o, mis_o, err_o, m_match, m_mis, m_err);
      end
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("FAIL exclusive: both-high cycles=%0d required 0", n_both);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_match();
    test_mismatch();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    test_exclusive();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
